// File: rtl/call_ret_stack_if.sv
// Request/response bundle between the jump decoder / fetch redirect logic and
// the return-address stack.
interface call_ret_stack_if #(
  parameter int PTR_W    = 4,
  parameter int IP_WIDTH = 48
);
  logic                push;
  logic                pop;
  logic [IP_WIDTH-1:0] push_addr;
  logic                restore_en;
  logic [PTR_W-1:0]    restore_ptr;
  logic [PTR_W:0]      restore_cnt;
  logic [IP_WIDTH-1:0] restore_addr;
  logic [IP_WIDTH-1:0] top_addr;
  logic                top_valid;
  logic [PTR_W-1:0]    ckpt_ptr;
  logic [PTR_W:0]      ckpt_cnt;
  logic                underflow;

  modport master (
    output push, pop, push_addr, restore_en, restore_ptr, restore_cnt, restore_addr,
    input  top_addr, top_valid, ckpt_ptr, ckpt_cnt, underflow
  );

  modport slave (
    input  push, pop, push_addr, restore_en, restore_ptr, restore_cnt, restore_addr,
    output top_addr, top_valid, ckpt_ptr, ckpt_cnt, underflow
  );
endinterface

// File: rtl/call_ret_stack.sv
// Circular return-address stack with checkpoint/restore for speculative
// call/return rollback. One operation per cycle, results visible next cycle.
module call_ret_stack #(
  parameter int DEPTH    = 16,
  parameter int PTR_W    = 4,
  parameter int IP_WIDTH = 48
) (
  input  logic           clk,
  input  logic           rst,
  call_ret_stack_if.slave bus
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [IP_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W:0]      cnt_q, cnt_d;
  logic                underflow_q, underflow_d;

  logic                wr_en;
  logic [PTR_W-1:0]    wr_idx;
  logic [IP_WIDTH-1:0] wr_data;

  function automatic logic [PTR_W:0] clamp_cnt(input logic [PTR_W:0] c);
    return (c > DEPTH_C) ? DEPTH_C : c;
  endfunction

  always_comb begin
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    underflow_d = 1'b0;
    wr_en       = 1'b0;
    wr_idx      = ptr_q;
    wr_data     = bus.push_addr;
    // Restore wins over any concurrent push/pop from the wrong path.
    if (bus.restore_en) begin
      ptr_d   = bus.restore_ptr;
      cnt_d   = clamp_cnt(bus.restore_cnt);
      wr_en   = 1'b1;
      wr_idx  = bus.restore_ptr;
      wr_data = bus.restore_addr;
    end else if (bus.push && bus.pop) begin
      wr_en = 1'b1;
      if (cnt_q == '0) cnt_d = (PTR_W+1)'(1);
    end else if (bus.push) begin
      ptr_d  = ptr_q + PTR_W'(1);
      wr_en  = 1'b1;
      wr_idx = ptr_q + PTR_W'(1);
      cnt_d  = clamp_cnt(cnt_q + (PTR_W+1)'(1));
    end else if (bus.pop) begin
      if (cnt_q != '0) begin
        ptr_d = ptr_q - PTR_W'(1);
        cnt_d = cnt_q - (PTR_W+1)'(1);
      end else begin
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      cnt_q       <= '0;
      underflow_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      underflow_q <= underflow_d;
    end
  end

  // Entries are never cleared; a reset only blocks the write that was pending.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem_q[wr_idx] <= wr_data;
  end

  assign bus.top_valid = (cnt_q != '0);
  assign bus.top_addr  = (cnt_q != '0) ? mem_q[ptr_q] : '0;
  assign bus.ckpt_ptr  = ptr_q;
  assign bus.ckpt_cnt  = cnt_q;
  assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_call_ret_stack.sv
// Randomized and directed bench for call_ret_stack against a circular-array
// reference model.
module tb_call_ret_stack;
  localparam int DEPTH = 16;
  localparam int PTR_W = 4;
  localparam int IPW   = 48;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  call_ret_stack_if #(.PTR_W(PTR_W), .IP_WIDTH(IPW)) bus ();

  call_ret_stack #(.DEPTH(DEPTH), .PTR_W(PTR_W), .IP_WIDTH(IPW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Reference model
  logic [IPW-1:0] m_mem [DEPTH];
  int             m_ptr, m_cnt;
  bit             m_uf;
  bit             chk_en = 1'b0;
  int             vectors = 0;
  int             fails = 0;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit ps, input bit pp, input logic [IPW-1:0] a,
                            input bit ren, input int rptr, input int rcnt,
                            input logic [IPW-1:0] raddr);
    m_uf = 1'b0;
    if (r) begin
      m_ptr = 0;
      m_cnt = 0;
    end else if (ren) begin
      m_ptr = rptr;
      m_cnt = (rcnt > DEPTH) ? DEPTH : rcnt;
      m_mem[rptr] = raddr;
    end else if (ps && pp) begin
      m_mem[m_ptr] = a;
      if (m_cnt == 0) m_cnt = 1;
    end else if (ps) begin
      m_ptr = (m_ptr + 1) % DEPTH;
      m_mem[m_ptr] = a;
      m_cnt = (m_cnt + 1 > DEPTH) ? DEPTH : m_cnt + 1;
    end else if (pp) begin
      if (m_cnt > 0) begin
        m_ptr = (m_ptr + DEPTH - 1) % DEPTH;
        m_cnt = m_cnt - 1;
      end else begin
        m_uf = 1'b1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("top_valid", 64'(bus.top_valid), 64'(m_cnt != 0));
      cmp("top_addr",  64'(bus.top_addr),  (m_cnt != 0) ? 64'(m_mem[m_ptr]) : 64'd0);
      cmp("ckpt_ptr",  64'(bus.ckpt_ptr),  64'(m_ptr));
      cmp("ckpt_cnt",  64'(bus.ckpt_cnt),  64'(m_cnt));
      cmp("underflow", 64'(bus.underflow), 64'(m_uf));
    end
  end

  // Apply one cycle of stimulus; returns just after the following falling edge.
  task automatic op(input bit r, input bit ps, input bit pp, input logic [IPW-1:0] a,
                    input bit ren = 1'b0, input int rptr = 0, input int rcnt = 0,
                    input logic [IPW-1:0] raddr = '0);
    rst              = r;
    bus.push         = ps;
    bus.pop          = pp;
    bus.push_addr    = a;
    bus.restore_en   = ren;
    bus.restore_ptr  = PTR_W'(rptr);
    bus.restore_cnt  = (PTR_W+1)'(rcnt);
    bus.restore_addr = raddr;
    @(posedge clk);
    model_step(r, ps, pp, a, ren, rptr, rcnt, raddr);
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    op(1'b0, 1'b0, 1'b0, '0);
  endtask

  int             rec_ptr, rec_cnt, base_ptr;
  logic [IPW-1:0] rec_top, ra;
  int             ck_ptr [$];
  int             ck_cnt [$];

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_ptr = 0; m_cnt = 0; m_uf = 1'b0;
    op(1'b1, 1'b0, 1'b0, '0);
    op(1'b1, 1'b0, 1'b0, '0);
    chk_en = 1'b1;

    cmp("rst_valid", 64'(bus.top_valid), 64'd0);
    cmp("rst_addr",  64'(bus.top_addr),  64'd0);
    cmp("rst_ptr",   64'(bus.ckpt_ptr),  64'd0);
    cmp("rst_cnt",   64'(bus.ckpt_cnt),  64'd0);
    cmp("rst_uf",    64'(bus.underflow), 64'd0);

    op(1'b0, 1'b1, 1'b0, 48'h1000); cmp("push1", 64'(bus.top_addr), 64'h1000);
    op(1'b0, 1'b1, 1'b0, 48'h2000); cmp("push2", 64'(bus.top_addr), 64'h2000);
    op(1'b0, 1'b1, 1'b0, 48'h3000); cmp("push3", 64'(bus.top_addr), 64'h3000);
    cmp("push_cnt", 64'(bus.ckpt_cnt), 64'd3);
    cmp("push_ptr", 64'(bus.ckpt_ptr), 64'd3);

    op(1'b0, 1'b0, 1'b1, '0); cmp("pop1", 64'(bus.top_addr), 64'h2000);
    op(1'b0, 1'b0, 1'b1, '0); cmp("pop2", 64'(bus.top_addr), 64'h1000);
    op(1'b0, 1'b0, 1'b1, '0); cmp("pop3", 64'(bus.top_addr), 64'h0);
    cmp("pop3_valid", 64'(bus.top_valid), 64'd0);
    op(1'b0, 1'b0, 1'b1, '0); cmp("uf_pulse", 64'(bus.underflow), 64'd1);
    cmp("uf_cnt", 64'(bus.ckpt_cnt), 64'd0);
    idle(); cmp("uf_clear", 64'(bus.underflow), 64'd0);

    // Push+pop on empty: occupancy becomes 1, no underflow.
    op(1'b0, 1'b1, 1'b1, 48'h7000);
    cmp("pp_empty_cnt", 64'(bus.ckpt_cnt), 64'd1);
    cmp("pp_empty_top", 64'(bus.top_addr), 64'h7000);
    cmp("pp_empty_uf",  64'(bus.underflow), 64'd0);
    op(1'b1, 1'b0, 1'b0, '0);

    // Overflow: 17 pushes, oldest lost.
    for (int i = 0; i <= 16; i++) op(1'b0, 1'b1, 1'b0, 48'hA000 + 48'(i));
    cmp("ovf_cnt", 64'(bus.ckpt_cnt), 64'd16);
    cmp("ovf_top", 64'(bus.top_addr), 64'hA010);
    for (int k = 0; k < 16; k++) begin
      cmp("ovf_pop_top", 64'(bus.top_addr), 64'hA000 + 64'(16 - k));
      op(1'b0, 1'b0, 1'b1, '0);
    end
    cmp("ovf_empty", 64'(bus.top_valid), 64'd0);

    // Simultaneous push+pop replaces the top.
    op(1'b0, 1'b1, 1'b0, 48'h1000);
    op(1'b0, 1'b1, 1'b0, 48'h2000);
    base_ptr = int'(bus.ckpt_ptr);
    op(1'b0, 1'b1, 1'b1, 48'h5000);
    cmp("pp_top", 64'(bus.top_addr), 64'h5000);
    cmp("pp_cnt", 64'(bus.ckpt_cnt), 64'd2);
    cmp("pp_ptr", 64'(bus.ckpt_ptr), 64'(base_ptr));

    // Checkpoint, speculate, restore alongside a push.
    rec_ptr = int'(bus.ckpt_ptr);
    rec_cnt = int'(bus.ckpt_cnt);
    rec_top = bus.top_addr;
    op(1'b0, 1'b1, 1'b0, 48'hB001);
    op(1'b0, 1'b1, 1'b0, 48'hB002);
    op(1'b0, 1'b1, 1'b0, 48'hB003);
    op(1'b0, 1'b0, 1'b1, '0);
    op(1'b0, 1'b1, 1'b0, 48'hBEEF, 1'b1, rec_ptr, rec_cnt, rec_top);
    cmp("rs_top", 64'(bus.top_addr), 64'h5000);
    cmp("rs_cnt", 64'(bus.ckpt_cnt), 64'd2);
    cmp("rs_ptr", 64'(bus.ckpt_ptr), 64'(rec_ptr));

    // Restore count above DEPTH clamps.
    op(1'b0, 1'b0, 1'b0, '0, 1'b1, 7, 31, 48'hC0DE);
    cmp("clamp_cnt", 64'(bus.ckpt_cnt), 64'd16);
    cmp("clamp_top", 64'(bus.top_addr), 64'hC0DE);

    // Reset in the middle of a push with five entries.
    op(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 5; i++) op(1'b0, 1'b1, 1'b0, 48'hD000 + 48'(i));
    cmp("pre_rst_cnt", 64'(bus.ckpt_cnt), 64'd5);
    op(1'b1, 1'b1, 1'b0, 48'hDEAD);
    cmp("mid_rst_cnt",   64'(bus.ckpt_cnt),  64'd0);
    cmp("mid_rst_valid", 64'(bus.top_valid), 64'd0);
    cmp("mid_rst_top",   64'(bus.top_addr),  64'd0);

    // Randomized traffic, all entries already written at least once.
    for (int n = 0; n < 3000; n++) begin
      int sel;
      sel = int'($urandom_range(0, 99));
      ra  = 48'({$urandom(), $urandom()});
      if ($urandom_range(0, 7) == 0) begin
        ck_ptr.push_back(int'(bus.ckpt_ptr));
        ck_cnt.push_back(int'(bus.ckpt_cnt));
        if (ck_ptr.size() > 8) begin
          void'(ck_ptr.pop_front());
          void'(ck_cnt.pop_front());
        end
      end
      if (sel < 1) begin
        op(1'b1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, ra);
      end else if (sel < 4) begin
        op(1'b0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, ra,
           1'b1, int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 31)),
           48'({$urandom(), $urandom()}));
      end else if (sel < 8 && ck_ptr.size() > 0) begin
        int j;
        j = int'($urandom_range(0, ck_ptr.size() - 1));
        op(1'b0, 1'b1, 1'b0, ra, 1'b1, ck_ptr[j], ck_cnt[j], 48'({$urandom(), $urandom()}));
      end else if (sel < 45) begin
        op(1'b0, 1'b1, 1'b0, ra);
      end else if (sel < 80) begin
        op(1'b0, 1'b0, 1'b1, ra);
      end else if (sel < 90) begin
        op(1'b0, 1'b1, 1'b1, ra);
      end else begin
        idle();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
